// File: rtl/bitrev_reorder_ctrl.sv
// Ping-pong bit-reversal reorder buffer for SDF FFT output.
// Writes at rev(arrival count), reads banks in natural order.
module bitrev_reorder_ctrl #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [N-1:0] out_idx,
  output logic         out_last,
  input  logic         out_ready,
  output logic         sof_err
);

  localparam int DEPTH = 1 << N;
  localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};
  localparam logic [N:0] CNT_ONE = {{N{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_FULL,
    S_DRAINING
  } bank_st_t;

  bank_st_t       r_st [2];
  bank_st_t       w_st_nxt [2];
  logic           r_wsel;
  logic           w_wsel_nxt;
  logic           r_rsel;
  logic           w_rsel_nxt;
  logic [N:0]     r_wr_cnt;
  logic [N:0]     w_wr_cnt_nxt;
  logic [N:0]     r_rd_cnt;
  logic [N:0]     w_rd_cnt_nxt;
  logic           r_sof_err;
  logic           w_sof_err_nxt;
  logic [W-1:0]   r_mem [2][DEPTH];
  logic [N-1:0]   w_waddr;
  logic           w_wr_open;
  logic           w_acc;
  logic           w_xfer;
  logic           w_realign;
  logic           w_wr_last;

  function automatic logic [N-1:0] f_rev(
    input logic [N-1:0] a
  );
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = a[N-1-i];
    end
    return r;
  endfunction

  assign w_wr_open = (r_st[r_wsel] == S_EMPTY) ||
                     (r_st[r_wsel] == S_FILLING);
  assign in_ready  = w_wr_open & rst_n;
  assign out_valid = (r_st[r_rsel] == S_FULL) ||
                     (r_st[r_rsel] == S_DRAINING);
  assign out_idx   = r_rd_cnt[N-1:0];
  assign out_data  = r_mem[r_rsel][out_idx];
  assign out_last  = out_valid && (r_rd_cnt == LAST);
  assign sof_err   = r_sof_err;

  assign w_acc     = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;
  assign w_realign = in_sof && (r_wr_cnt != '0);
  assign w_wr_last = (r_wr_cnt == LAST);
  assign w_waddr   = w_realign ? '0 : f_rev(r_wr_cnt[N-1:0]);

  // Next-state for bank states, pointers, counters and sof_err.
  always_comb begin
    w_st_nxt[0]   = r_st[0];
    w_st_nxt[1]   = r_st[1];
    w_wsel_nxt    = r_wsel;
    w_rsel_nxt    = r_rsel;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_sof_err_nxt = 1'b0;
    if (w_acc) begin
      if (w_realign) begin
        w_st_nxt[r_wsel] = S_FILLING;
        w_wr_cnt_nxt     = CNT_ONE;
        w_sof_err_nxt    = 1'b1;
      end else if (w_wr_last) begin
        w_st_nxt[r_wsel] = S_FULL;
        w_wr_cnt_nxt     = '0;
        w_wsel_nxt       = ~r_wsel;
      end else begin
        w_st_nxt[r_wsel] = S_FILLING;
        w_wr_cnt_nxt     = r_wr_cnt + CNT_ONE;
      end
    end
    if (w_xfer) begin
      if (out_last) begin
        w_st_nxt[r_rsel] = S_EMPTY;
        w_rd_cnt_nxt     = '0;
        w_rsel_nxt       = ~r_rsel;
      end else begin
        w_st_nxt[r_rsel] = S_DRAINING;
        w_rd_cnt_nxt     = r_rd_cnt + CNT_ONE;
      end
    end
  end

  // Control state register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st[0]   <= S_EMPTY;
      r_st[1]   <= S_EMPTY;
      r_wsel    <= 1'b0;
      r_rsel    <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_sof_err <= 1'b0;
    end else begin
      r_st[0]   <= w_st_nxt[0];
      r_st[1]   <= w_st_nxt[1];
      r_wsel    <= w_wsel_nxt;
      r_rsel    <= w_rsel_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_sof_err <= w_sof_err_nxt;
    end
  end

  // Sample storage; contents are qualified by bank state.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[r_wsel][w_waddr] <= in_data;
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Directed bench for bitrev_reorder_ctrl.
// Expected order comes from a hand-built N=3 permutation table.
module tb_bitrev_reorder_ctrl;

  localparam int N = 3;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_idx;
  logic         out_last;
  logic         out_ready;
  logic         sof_err;

  bitrev_reorder_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int PERM [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [31:0] exp_q [$];
  int          exp_i [$];
  logic [31:0] mf [8];
  int          mcnt = 0;
  logic        exp_err = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [N-1:0] hold_i;
  int          n_sof_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check, model, advance to next negedge.
  task automatic step(input logic v, input logic sof,
                      input logic [31:0] d, input logic ordy,
                      output logic acc);
    logic [31:0] ed;
    int          ei;
    in_valid  = v;
    in_sof    = sof;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, ((exp_q.size() + 7) / 8) < 2);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("sof_err", sof_err, exp_err);
    if (sof_err) n_sof_err++;
    exp_err = 1'b0;
    if (hold_v) begin
      chk("hold_data", out_data, hold_d);
      chk("hold_idx", out_idx, hold_i);
    end
    hold_v = out_valid && !ordy;
    hold_d = out_data;
    hold_i = out_idx;
    if (out_valid && ordy && exp_q.size() != 0) begin
      ed = exp_q.pop_front();
      ei = exp_i.pop_front();
      chk("out_data", out_data, ed);
      chk("out_idx", out_idx, ei);
      chk("out_last", out_last, ei == 7);
    end
    acc = v && in_ready;
    if (acc) begin
      if (sof && mcnt != 0) begin
        mcnt = 0;
        exp_err = 1'b1;
      end
      mf[mcnt] = d;
      mcnt++;
      if (mcnt == 8) begin
        for (int j = 0; j < 8; j++) begin
          exp_q.push_back(mf[PERM[j]]);
          exp_i.push_back(j);
        end
        mcnt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic sof,
                      input logic ordy);
    logic acc;
    int   t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      step(1'b1, sof, d, ordy, acc);
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, acc);
    end
    chk("drain_empty", exp_q.size(), 0);
    step(1'b0, 1'b0, 32'd0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_out_idx", out_idx, 0);
    rst_n = 1'b1;

    // single frame
    for (int i = 0; i < 8; i++) send(i, i == 0, 1'b1);
    drain();

    // streaming 4 frames
    for (int i = 0; i < 32; i++) send(i, (i % 8) == 0, 1'b1);
    drain();

    // backpressure
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (cnt % 8) == 0, 200 + cnt, 1'b0, acc);
      if (acc) cnt++;
    end
    chk("bp_accepted", cnt, 16);
    while (cnt < 24) begin
      send(200 + cnt, (cnt % 8) == 0, 1'b1);
      cnt++;
    end
    drain();

    // realignment
    n_sof_err = 0;
    for (int i = 0; i < 3; i++) send(50 + i, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(100 + i, i == 0, 1'b1);
    drain();
    chk("sof_err_pulses", n_sof_err, 1);

    // reset mid-operation
    for (int i = 0; i < 8; i++) send(300 + i, i == 0, 1'b0);
    for (int i = 0; i < 5; i++) send(400 + i, i == 0, i < 3);
    chk("mid_idx", out_idx, 3);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    exp_i.delete();
    mcnt = 0;
    exp_err = 1'b0;
    hold_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(i, i == 0, 1'b1);
    drain();

    // random handshakes, 20 frames
    cnt = 0;
    for (int t = 0; t < 3000 && cnt < 160; t++) begin
      step(1'($urandom_range(0, 1)), (cnt % 8) == 0, 1000 + cnt,
           1'($urandom_range(0, 1)), acc);
      if (acc) cnt++;
    end
    chk("rnd_accepted", cnt, 160);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bitrev_reorder_ctrl.md
# bitrev_reorder_ctrl

Ping-pong reorder buffer and sequencer at the output of the radix-2 SDF FFT pipeline. The FFT produces frames of 2^N samples in bit-reversed order; this block writes each sample at the bit-reversed address of its arrival count and reads the banks in natural order. The two banks let one frame fill while the previous one drains. Both sides use valid/ready handshakes so the block sits between the last butterfly stage and any downstream consumer.

## Interface
- N, 3: log2 of the frame length; a frame is 2^N samples.
- W, 32: sample width in bits, e.g. packed {re, im}.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  input sample present.
- in_sof  in  1  marks the first sample of a frame; sampled only when in_valid is high.
- in_data  in  W  input sample, bit-reversed frame order.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  output sample present.
- out_data  out  W  output sample, natural order.
- out_idx  out  N  natural-order index of out_data.
- out_last  out  1  high with the final sample (index 2^N-1) of a frame.
- out_ready  in  1  downstream accepts the sample.
- sof_err  out  1  one-cycle pulse when an in_sof realigns a partial frame.

## Operation
- Storage: two banks, mem[b][0..2^N-1], each W bits. Each bank has a registered state: EMPTY, FILLING, FULL or DRAINING.
- Write side: pointer wsel (reset 0) and counter wr_cnt (N+1 bits, reset 0).
- Read side: pointer rsel (reset 0) and counter rd_cnt (N+1 bits, reset 0).
- in_ready = (state[wsel] is EMPTY or FILLING) and rst_n.
- A sample is accepted when in_valid and in_ready are both high.
- On accept, in_data is written to mem[wsel][rev(wr_cnt[N-1:0])], where rev swaps bit i with bit N-1-i.
- wr_cnt increments on each accept, and state[wsel] goes to FILLING.
- When the accepted sample has wr_cnt == 2^N-1:
  - state[wsel] goes to FULL;
  - wr_cnt returns to 0;
  - wsel toggles.
- SOF realignment: if in_sof is accepted with wr_cnt != 0:
  - the partial frame is discarded;
  - this sample is written as index 0 (address 0) and wr_cnt becomes 1;
  - sof_err pulses for one cycle.
- in_sof with wr_cnt == 0 has no effect. Frames without any in_sof are accepted, so in_sof is optional.
- Read side:
  - out_valid = state[rsel] is FULL or DRAINING.
  - out_data = mem[rsel][rd_cnt[N-1:0]] and out_idx = rd_cnt[N-1:0], both combinational from registered state.
  - out_last = out_valid and (rd_cnt == 2^N-1).
- On an output transfer (out_valid and out_ready):
  - rd_cnt increments and state[rsel] goes to DRAINING.
  - On out_last, state[rsel] goes to EMPTY, rd_cnt returns to 0 and rsel toggles.
- While out_valid is high and out_ready is low, out_data, out_idx and out_last hold stable.
- Simultaneous events:
  - Write completion on one bank and drain completion on the other in the same cycle both take effect; there is no priority conflict.
  - A bank freed this cycle is not writable until the next cycle, because in_ready comes from registered state.
- The block is in-order: output frame order equals input frame order.

## Timing
- Reset (rst_n low), asynchronous:
  - All bank states EMPTY; wsel, rsel, wr_cnt and rd_cnt all 0.
  - Outputs: out_valid=0, out_last=0, sof_err=0, in_ready=0, out_idx=0, out_data don't-care.
- in_ready rises in the first cycle rst_n is high.
- Reset mid-frame discards all stored and partial frames with no output.
- Latency: the last input sample of a frame is accepted at edge k. out_valid is high in the cycle after edge k, with index 0 presented.
- Throughput: with out_ready held high, one sample per cycle in and out indefinitely; in_ready never drops.
- With out_ready held low, at most 2 complete frames are stored. in_ready drops in the cycle after the 2·2^N-th accept.
- in_ready recovers in the cycle after the out_last transfer that frees a bank.
- sof_err is registered: it is high for the cycle after the offending accept.

## Test plan
- Single frame, N=3, W=32: inputs 0..7 in arrival order, in_sof on the first, out_ready=1. Required: out_data 0,4,2,6,1,5,3,7 with out_idx 0..7; out_last only on out_data=7; out_valid first high the cycle after the 8th accept.
- Streaming: 4 back-to-back frames (values 0..31), out_ready=1. Required: in_ready stays 1 throughout; each frame is output in the permutation above, offset by 8·frame; gap-free output after first latency.
- Backpressure: out_ready=0 while feeding 24 samples. Required: exactly 16 accepted; in_ready=0 from the cycle after the 16th accept; out_data/out_idx stable. Then raise out_ready: in_ready returns the cycle after the first out_last, and all 24 samples come out correct.
- Realignment: 3 samples (no sof), then in_sof with values 100..107. Required: sof_err pulses once; the output frame is 100,104,102,106,101,105,103,107; the first 3 samples never appear.
- Reset mid-operation: assert rst_n low after 5 accepts of frame 2 while frame 1 is draining at index 3. Required: out_valid=0 and in_ready=0 immediately; after release, a fresh frame 0..7 produces the exact single-frame result.
- Random in_valid/out_ready at 50% each, 20 frames. Required: the output matches the bit-reversal reference model sample-for-sample; no drops or duplicates.
